// File: rtl/k12_nonce_scheduler_if.sv
// Job, hash-core and result signals of the K12 nonce scheduler.
// The master modport is the scheduler side and the slave modport is the environment side.
interface k12_nonce_scheduler_if;
  localparam int unsigned STATE_W  = 1600;
  localparam int unsigned HASH_W   = 256;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned TARGET_W = 64;
  localparam int unsigned COUNT_W  = 32;

  // job control
  logic                job_load;
  logic [STATE_W-1:0]  job_blob;
  logic [TARGET_W-1:0] job_target;
  logic [NONCE_W-1:0]  nonce_first;
  logic [NONCE_W-1:0]  nonce_last;
  logic                abort;

  // hash core
  logic                k12_start;
  logic [STATE_W-1:0]  k12_data;
  logic [HASH_W-1:0]   k12_hash;
  logic                k12_valid;

  // results and status
  logic                found_valid;
  logic [NONCE_W-1:0]  found_nonce;
  logic [TARGET_W-1:0] found_word;
  logic                busy;
  logic                done;
  logic                timeout_err;
  logic [COUNT_W-1:0]  hash_count;

  modport master (
    input  job_load, job_blob, job_target, nonce_first, nonce_last, abort,
    input  k12_hash, k12_valid,
    output k12_start, k12_data,
    output found_valid, found_nonce, found_word, busy, done, timeout_err, hash_count
  );

  modport slave (
    output job_load, job_blob, job_target, nonce_first, nonce_last, abort,
    output k12_hash, k12_valid,
    input  k12_start, k12_data,
    input  found_valid, found_nonce, found_word, busy, done, timeout_err, hash_count
  );
endinterface

// File: rtl/k12_nonce_scheduler.sv
// Sweeps an inclusive nonce range through the K12 hash core, compares each hash's
// top word against the job target and reports every winning nonce.
module k12_nonce_scheduler #(
  parameter int unsigned NONCE_LSB = 312,
  parameter int unsigned TIMEOUT   = 31
) (
  input logic                   clk,
  input logic                   rst,
  k12_nonce_scheduler_if.master bus
);
  localparam int unsigned STATE_W  = 1600;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned TARGET_W = 64;
  localparam int unsigned COUNT_W  = 32;
  localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_GUARD  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [STATE_W-1:0]  blob_q, blob_d;
  logic [TARGET_W-1:0] target_q, target_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [NONCE_W-1:0]  last_q, last_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                k12_start_q, k12_start_d;
  logic [STATE_W-1:0]  k12_data_q, k12_data_d;
  logic                found_valid_q, found_valid_d;
  logic [NONCE_W-1:0]  found_nonce_q, found_nonce_d;
  logic [TARGET_W-1:0] found_word_q, found_word_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                timeout_err_q, timeout_err_d;
  logic [COUNT_W-1:0]  hash_count_q, hash_count_d;

  logic [TARGET_W-1:0] hash_top_c;
  logic                hit_c;
  logic                unused_hash_c;

  // Only the top 64 bits of the hash take part in the comparison.
  assign hash_top_c    = bus.k12_hash[255:192];
  assign hit_c         = hash_top_c < target_q;
  assign unused_hash_c = ^bus.k12_hash[191:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      blob_q        <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      last_q        <= '0;
      wait_cnt_q    <= '0;
      k12_start_q   <= 1'b0;
      k12_data_q    <= '0;
      found_valid_q <= 1'b0;
      found_nonce_q <= '0;
      found_word_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      hash_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      blob_q        <= blob_d;
      target_q      <= target_d;
      nonce_q       <= nonce_d;
      last_q        <= last_d;
      wait_cnt_q    <= wait_cnt_d;
      k12_start_q   <= k12_start_d;
      k12_data_q    <= k12_data_d;
      found_valid_q <= found_valid_d;
      found_nonce_q <= found_nonce_d;
      found_word_q  <= found_word_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      hash_count_q  <= hash_count_d;
    end
  end

  // Next state plus next values of every output flop; outputs follow state_d so
  // they line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    blob_d        = blob_q;
    target_d      = target_q;
    nonce_d       = nonce_q;
    last_d        = last_q;
    wait_cnt_d    = wait_cnt_q;
    k12_start_d   = 1'b0;
    k12_data_d    = k12_data_q;
    found_valid_d = 1'b0;
    found_nonce_d = found_nonce_q;
    found_word_d  = found_word_q;
    busy_d        = 1'b0;
    done_d        = done_q;
    timeout_err_d = timeout_err_q;
    hash_count_d  = hash_count_q;

    if (bus.abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end else if (bus.job_load) begin
      // A new job preempts whatever is in flight; its result is dropped.
      blob_d        = bus.job_blob;
      target_d      = bus.job_target;
      nonce_d       = bus.nonce_first;
      last_d        = bus.nonce_last;
      done_d        = 1'b0;
      timeout_err_d = 1'b0;
      hash_count_d  = '0;
      state_d       = ST_LAUNCH;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LAUNCH: state_d = ST_GUARD;
        // The core may still present the previous result here.
        ST_GUARD: begin
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.k12_valid) begin
            state_d = ST_CHECK;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
              timeout_err_d = 1'b1;
              state_d       = ST_IDLE;
            end
          end
        end
        ST_CHECK: begin
          hash_count_d = hash_count_q + COUNT_W'(1);
          if (hit_c) begin
            found_valid_d = 1'b1;
            found_nonce_d = nonce_q;
            found_word_d  = hash_top_c;
          end
          if (nonce_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            state_d = ST_LAUNCH;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_LAUNCH) begin
      k12_start_d                          = 1'b1;
      k12_data_d                           = blob_d;
      k12_data_d[NONCE_LSB +: NONCE_W]     = nonce_d;
    end
    busy_d = (state_d == ST_LAUNCH) || (state_d == ST_GUARD) ||
             (state_d == ST_WAIT)   || (state_d == ST_CHECK);
    if (state_d == ST_DONE) begin
      done_d = 1'b1;
    end
  end

  assign bus.k12_start   = k12_start_q;
  assign bus.k12_data    = k12_data_q;
  assign bus.found_valid = found_valid_q;
  assign bus.found_nonce = found_nonce_q;
  assign bus.found_word  = found_word_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.hash_count  = hash_count_q;

endmodule

// File: tb/tb_k12_nonce_scheduler.sv
// Bench for k12_nonce_scheduler: a latency-13 core model whose hash top word is
// {n^0x12, n^0x12}, a table of sweeps, and directed abort/timeout/reset sequences.
module tb_k12_nonce_scheduler;
  localparam int unsigned NONCE_LSB = 312;
  localparam int unsigned LAT       = 13;
  localparam logic [63:0] ONES      = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  k12_nonce_scheduler_if bus ();

  k12_nonce_scheduler #(.NONCE_LSB(NONCE_LSB), .TIMEOUT(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // core model: 0 = normal, 1 = never valid, 2 = valid driven by hand
  int unsigned core_mode = 0;
  logic        man_valid = 1'b0;
  logic        model_valid;
  int unsigned lat_cnt;

  function automatic logic [63:0] top_of(input logic [31:0] n);
    return {n ^ 32'h12, n ^ 32'h12};
  endfunction

  function automatic logic [1599:0] blob_of(input logic [31:0] f);
    return {25{f, 32'hC3A5_5A3C}};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_valid <= 1'b0;
      lat_cnt     <= 0;
    end else if (bus.k12_start) begin
      model_valid <= 1'b0;
      lat_cnt     <= LAT;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && core_mode == 0) model_valid <= 1'b1;
    end
  end

  assign bus.k12_valid = (core_mode == 2) ? man_valid : model_valid;
  assign bus.k12_hash  = {top_of(bus.k12_data[NONCE_LSB +: 32]), {6{32'hDEAD_BEEF}}};

  // monitor
  int unsigned      cyc = 0;
  logic [31:0]      l_nonce[$];
  int unsigned      l_cyc[$];
  logic [1599:0]    l_data[$];
  logic [31:0]      f_nonce[$];
  logic [63:0]      f_word[$];
  int unsigned      done_cyc, to_cyc;
  logic             done_prev = 1'b0, to_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.k12_start) begin
        l_nonce.push_back(bus.k12_data[NONCE_LSB +: 32]);
        l_cyc.push_back(cyc);
        l_data.push_back(bus.k12_data);
      end
      if (bus.found_valid) begin
        f_nonce.push_back(bus.found_nonce);
        f_word.push_back(bus.found_word);
      end
      if (bus.done && !done_prev) done_cyc = cyc;
      if (bus.timeout_err && !to_prev) to_cyc = cyc;
    end
    done_prev = bus.done;
    to_prev   = bus.timeout_err;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned lc(input int i);
    return (i < l_cyc.size()) ? l_cyc[i] : 0;
  endfunction
  function automatic logic [31:0] ln(input int i);
    return (i < l_nonce.size()) ? l_nonce[i] : 32'h0;
  endfunction
  function automatic logic [31:0] fn(input int i);
    return (i < f_nonce.size()) ? f_nonce[i] : 32'h0;
  endfunction
  function automatic logic [63:0] fw(input int i);
    return (i < f_word.size()) ? f_word[i] : 64'h0;
  endfunction

  task automatic clear_mon();
    l_nonce.delete(); l_cyc.delete(); l_data.delete();
    f_nonce.delete(); f_word.delete();
    done_cyc = 0; to_cyc = 0;
  endtask

  task automatic load(input logic [31:0] f, input logic [31:0] l, input logic [63:0] t);
    @(posedge clk); #1;
    bus.job_load    = 1'b1;
    bus.nonce_first = f;
    bus.nonce_last  = l;
    bus.job_target  = t;
    bus.job_blob    = blob_of(f);
    @(posedge clk); #1;
    bus.job_load = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      if (bus.done || bus.timeout_err) begin ok = 1'b1; break; end
    end
    chk({name, "_end_reached"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_launch(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (l_nonce.size() > 0) begin ok = 1'b1; break; end
    end
    chk({name, "_launch_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_k12_start"},   64'(bus.k12_start), 64'd0);
    chk({tag, "_found_valid"}, 64'(bus.found_valid), 64'd0);
    chk({tag, "_busy"},        64'(bus.busy), 64'd0);
    chk({tag, "_done"},        64'(bus.done), 64'd0);
    chk({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
    chk({tag, "_found_nonce"}, 64'(bus.found_nonce), 64'd0);
    chk({tag, "_found_word"},  bus.found_word, 64'd0);
    chk({tag, "_hash_count"},  64'(bus.hash_count), 64'd0);
    chk({tag, "_k12_data"},    64'(bus.k12_data == '0), 64'd1);
  endtask

  typedef struct {
    logic [31:0] first;
    logic [31:0] last;
    logic [63:0] target;
    int unsigned n_launch;
    int unsigned n_found;
    logic [31:0] f_nonce;
    logic [63:0] f_word;
  } vec_t;

  vec_t          vecs[5];
  logic [31:0]   en;
  logic [1599:0] exp_data;
  string         nm;

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0005, ONES, 1, 1, 32'h0000_0005, 64'h0000_0017_0000_0017};
    vecs[1] = '{32'h0000_0010, 32'h0000_0013, 64'h0000_0001_0000_0000, 4, 1, 32'h0000_0012, 64'h0};
    vecs[2] = '{32'hFFFF_FFFE, 32'h0000_0001, 64'h0, 4, 0, 32'h0, 64'h0};
    vecs[3] = '{32'hFFFF_FFED, 32'hFFFF_FFED, ONES, 1, 0, 32'h0, 64'h0};
    vecs[4] = '{32'h0000_0012, 32'h0000_0012, 64'h1, 1, 1, 32'h0000_0012, 64'h0};

    bus.job_load = 1'b0; bus.job_blob = '0; bus.job_target = '0;
    bus.nonce_first = '0; bus.nonce_last = '0; bus.abort = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 5; v++) begin
      nm = $sformatf("v%0d", v);
      clear_mon();
      load(vecs[v].first, vecs[v].last, vecs[v].target);
      wait_end(nm);
      repeat (2) @(negedge clk);
      #1;
      chk({nm, "_launches"}, 64'(l_nonce.size()), 64'(vecs[v].n_launch));
      for (int i = 0; i < l_nonce.size(); i++) begin
        en       = vecs[v].first + 32'(i);
        exp_data = blob_of(vecs[v].first);
        exp_data[NONCE_LSB +: 32] = en;
        chk($sformatf("%s_launch%0d_nonce", nm, i), 64'(ln(i)), 64'(en));
        chk($sformatf("%s_launch%0d_data", nm, i), 64'(l_data[i] == exp_data), 64'd1);
        if (i > 0) chk($sformatf("%s_period%0d", nm, i), 64'(lc(i) - lc(i - 1)), 64'd16);
      end
      chk({nm, "_found_cnt"}, 64'(f_nonce.size()), 64'(vecs[v].n_found));
      if (vecs[v].n_found != 0) begin
        chk({nm, "_found_nonce"}, 64'(fn(0)), 64'(vecs[v].f_nonce));
        chk({nm, "_found_word"},  fw(0), vecs[v].f_word);
      end
      chk({nm, "_hash_count"}, 64'(bus.hash_count), 64'(vecs[v].n_launch));
      chk({nm, "_done_latency"}, 64'(done_cyc - lc(l_cyc.size() - 1)), 64'd16);
      chk({nm, "_done_held"}, 64'(bus.done), 64'd1);
      chk({nm, "_busy_low"}, 64'(bus.busy), 64'd0);
      chk({nm, "_no_timeout"}, 64'(bus.timeout_err), 64'd0);
    end

    // hung core: timeout 31 cycles after WAIT is entered (launch + 2)
    core_mode = 1;
    clear_mon();
    load(32'h7, 32'h9, ONES);
    wait_end("hung");
    #1;
    chk("hung_timeout_err", 64'(bus.timeout_err), 64'd1);
    chk("hung_timeout_cycle", 64'(to_cyc - lc(0)), 64'd33);
    chk("hung_busy", 64'(bus.busy), 64'd0);
    chk("hung_done", 64'(bus.done), 64'd0);
    chk("hung_launches", 64'(l_nonce.size()), 64'd1);
    chk("hung_found", 64'(f_nonce.size()), 64'd0);
    core_mode = 0;

    // abort coinciding with a passing CHECK
    clear_mon();
    load(32'h5, 32'h6, ONES);
    wait_launch("abort");
    repeat (15) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("abort_found", 64'(f_nonce.size()), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_launches", 64'(l_nonce.size()), 64'd1);
    clear_mon();
    load(32'h20, 32'h20, ONES);
    chk("restart_hash_count_clear", 64'(bus.hash_count), 64'd0);
    wait_end("restart");
    chk("restart_found_cnt", 64'(f_nonce.size()), 64'd1);
    chk("restart_found_nonce", 64'(fn(0)), 64'h20);
    chk("restart_hash_count", 64'(bus.hash_count), 64'd1);

    // job_load while busy preempts the running sweep
    clear_mon();
    load(32'h50, 32'h53, ONES);
    wait_launch("preempt");
    repeat (5) @(posedge clk);
    load(32'h60, 32'h60, ONES);
    wait_end("preempt");
    #1;
    chk("preempt_launches", 64'(l_nonce.size()), 64'd2);
    chk("preempt_new_nonce", 64'(ln(1)), 64'h60);
    chk("preempt_relaunch_gap", 64'(lc(1) - lc(0)), 64'd7);
    chk("preempt_found_cnt", 64'(f_nonce.size()), 64'd1);
    chk("preempt_found_nonce", 64'(fn(0)), 64'h60);
    chk("preempt_found_word", fw(0), 64'h0000_0072_0000_0072);
    chk("preempt_hash_count", 64'(bus.hash_count), 64'd1);

    // reset during WAIT, then a job whose GUARD cycle sees a stale valid
    clear_mon();
    load(32'h30, 32'h31, ONES);
    wait_launch("rst");
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1 rst = 1'b1;
    core_mode = 2;
    man_valid = 1'b1;
    clear_mon();
    load(32'h40, 32'h40, ONES);
    wait_launch("guard");
    @(posedge clk);
    @(posedge clk); #1 man_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("guard_still_busy", 64'(bus.busy), 64'd1);
    chk("guard_no_check", 64'(bus.hash_count), 64'd0);
    chk("guard_no_found", 64'(f_nonce.size()), 64'd0);
    @(posedge clk); #1 man_valid = 1'b1;
    wait_end("guard");
    chk("guard_launch_nonce", 64'(ln(0)), 64'h40);
    chk("guard_found_nonce", 64'(fn(0)), 64'h40);
    chk("guard_done", 64'(bus.done), 64'd1);
    chk("guard_hash_count", 64'(bus.hash_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
